// File: rtl/video_pattern_checker.sv
// video_pattern_checker
// Receive-side checker for an RGB565 test-pattern stream. Rebuilds (x, y)
// from rgb565_valid runs, compares each pixel against the selected pattern,
// checks frame geometry and publishes per-frame results on frame_done.
// Optional feature: define VIDEO_CHECKER_CRC_EN to build the CRC-16-CCITT
// frame signature on crc_out; otherwise crc_out is tied to zero.
// state_dbg exposes the FSM state (0 = IDLE, 1 = ACTIVE).
//
// Stream semantics: there is no backpressure. Every cycle with rgb565_valid
// high carries one pixel; a maximal run of valid cycles is one line. A
// frame_start pulse closes the current frame and opens the next one; if it
// lands on a valid pixel, that pixel belongs to the frame being closed.
module video_pattern_checker #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk_pixel,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [2:0]  pattern_sel,
    input  logic [15:0] rgb565,
    input  logic        rgb565_valid,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [19:0] mismatch_count,
    output logic        line_len_err,
    output logic        line_count_err,
    output logic [9:0]  last_line_count,
    output logic [15:0] frame_count,
    output logic [15:0] crc_out,
    output logic        state_dbg
);

    localparam logic [9:0] H_LEN = 10'(H_ACTIVE);
    localparam logic [9:0] V_LEN = 10'(V_ACTIVE);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t      state;
    logic [2:0]  pat_q;
    logic [9:0]  x_cnt, y_cnt;
    logic        valid_d;
    logic        len_err_q;
    logic [19:0] mis_cnt;
    logic        cmp_mis_q;
    logic        close_pend;
    logic [19:0] mm_pend;
    logic [9:0]  lines_pend;
    logic        len_err_pend;

    logic [15:0] exp_colour;
    logic [9:0]  x_inc, y_inc, close_len;
    logic        in_range, mis_now, line_open;
    logic [19:0] mis_acc, mm_final;

    assign state_dbg = (state == ACTIVE);

    // Expected colour for the current coordinates under the latched pattern
    always_comb begin
        exp_colour = 16'h0000;
        case (pat_q)
            3'd0: begin
                if      (x_cnt[9:4] < 6'd5)  exp_colour = 16'hFFFF;
                else if (x_cnt[9:4] < 6'd10) exp_colour = 16'hFFE0;
                else if (x_cnt[9:4] < 6'd15) exp_colour = 16'h07FF;
                else if (x_cnt[9:4] < 6'd20) exp_colour = 16'h07E0;
                else if (x_cnt[9:4] < 6'd25) exp_colour = 16'hF81F;
                else if (x_cnt[9:4] < 6'd30) exp_colour = 16'hF800;
                else if (x_cnt[9:4] < 6'd35) exp_colour = 16'h001F;
                else                         exp_colour = 16'h0000;
            end
            3'd1: exp_colour = {x_cnt[9:5], 11'b0};
            3'd2: exp_colour = {5'b0, y_cnt[8:4], 6'b0};
            3'd3: exp_colour = (x_cnt[4:0] == 5'd0 || y_cnt[4:0] == 5'd0) ? 16'hFFFF : 16'h0000;
            3'd4: exp_colour = (x_cnt[5] ^ y_cnt[5]) ? 16'hFFFF : 16'h0000;
            3'd5: begin
                case (y_cnt[8:7])
                    2'd0:    exp_colour = 16'hF800;
                    2'd1:    exp_colour = 16'h07E0;
                    2'd2:    exp_colour = 16'h001F;
                    default: exp_colour = 16'hFFFF;
                endcase
            end
            3'd6: exp_colour = 16'hFFFF;
            default: exp_colour = 16'h0000;
        endcase
    end

    // Saturating counters, compare decision and close-time line view
    always_comb begin
        x_inc     = (x_cnt == 10'h3FF) ? x_cnt : x_cnt + 10'd1;
        y_inc     = (y_cnt == 10'h3FF) ? y_cnt : y_cnt + 10'd1;
        in_range  = (x_cnt < H_LEN) && (y_cnt < V_LEN);
        mis_now   = (state == ACTIVE) && rgb565_valid && in_range && (rgb565 != exp_colour);
        line_open = rgb565_valid || valid_d;
        close_len = rgb565_valid ? x_inc : x_cnt;
        mis_acc   = (cmp_mis_q && mis_cnt != 20'hFFFFF) ? mis_cnt + 20'd1 : mis_cnt;
        mm_final  = (cmp_mis_q && mm_pend != 20'hFFFFF) ? mm_pend + 20'd1 : mm_pend;
    end

    // Frame FSM: coordinate tracking, working results, and result latch
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            state           <= IDLE;
            pat_q           <= 3'd0;
            x_cnt           <= 10'd0;
            y_cnt           <= 10'd0;
            valid_d         <= 1'b0;
            len_err_q       <= 1'b0;
            mis_cnt         <= 20'd0;
            cmp_mis_q       <= 1'b0;
            close_pend      <= 1'b0;
            mm_pend         <= 20'd0;
            lines_pend      <= 10'd0;
            len_err_pend    <= 1'b0;
            frame_done      <= 1'b0;
            frame_ok        <= 1'b0;
            mismatch_count  <= 20'd0;
            line_len_err    <= 1'b0;
            line_count_err  <= 1'b0;
            last_line_count <= 10'd0;
            frame_count     <= 16'd0;
        end else begin
            frame_done <= 1'b0;
            close_pend <= 1'b0;
            cmp_mis_q  <= mis_now;
            if (state == IDLE) begin
                valid_d <= 1'b0;
                if (frame_start) begin
                    state     <= ACTIVE;
                    pat_q     <= pattern_sel;
                    x_cnt     <= 10'd0;
                    y_cnt     <= 10'd0;
                    len_err_q <= 1'b0;
                    mis_cnt   <= 20'd0;
                end
            end else begin
                valid_d <= rgb565_valid;
                // The compare stage result during the drain cycle belongs to
                // the closed frame, so it goes to the latch, not the new count.
                if (!close_pend) mis_cnt <= mis_acc;
                if (close_pend) begin
                    frame_done      <= 1'b1;
                    mismatch_count  <= mm_final;
                    line_len_err    <= len_err_pend;
                    line_count_err  <= (lines_pend != V_LEN);
                    last_line_count <= lines_pend;
                    frame_ok        <= (mm_final == 20'd0) && !len_err_pend && (lines_pend == V_LEN);
                    frame_count     <= frame_count + 16'd1;
                end
                if (frame_start) begin
                    // Snapshot the closing frame (including any open line),
                    // then restart the working state for the next frame.
                    mm_pend      <= close_pend ? mis_cnt : mis_acc;
                    lines_pend   <= line_open ? y_inc : y_cnt;
                    len_err_pend <= len_err_q | (line_open && close_len != H_LEN);
                    close_pend   <= 1'b1;
                    pat_q        <= pattern_sel;
                    x_cnt        <= 10'd0;
                    y_cnt        <= 10'd0;
                    len_err_q    <= 1'b0;
                    mis_cnt      <= 20'd0;
                    valid_d      <= 1'b0;
                end else if (rgb565_valid) begin
                    x_cnt <= x_inc;
                end else if (valid_d) begin
                    if (x_cnt != H_LEN) len_err_q <= 1'b1;
                    x_cnt <= 10'd0;
                    y_cnt <= y_inc;
                end
            end
        end
    end

`ifdef VIDEO_CHECKER_CRC_EN
    logic [15:0] crc_q, crc_next, crc_pend;

    // CRC-16-CCITT step over one pixel, MSB first
    always_comb begin
        crc_next = crc_q;
        if (rgb565_valid) begin
            for (int i = 15; i >= 0; i--) begin
                if (crc_next[15] ^ rgb565[i]) crc_next = {crc_next[14:0], 1'b0} ^ 16'h1021;
                else                          crc_next = {crc_next[14:0], 1'b0};
            end
        end
    end

    // Working CRC, close-time snapshot and published signature
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            crc_q    <= 16'hFFFF;
            crc_pend <= 16'h0000;
            crc_out  <= 16'h0000;
        end else begin
            if (state == ACTIVE && close_pend) crc_out <= crc_pend;
            if (frame_start) begin
                if (state == ACTIVE) crc_pend <= crc_next;
                crc_q <= 16'hFFFF;
            end else if (state == ACTIVE) begin
                crc_q <= crc_next;
            end
        end
    end
`else
    assign crc_out = 16'h0000;
`endif

endmodule
